// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants, fetch buffer entry type and field helper
package rv32i_pkg;
  localparam int XLEN   = 32;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int REG_AW  = 5;

  localparam logic [XLEN-1:0] RV32I_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [REG_AW-1:0] reg_field(input logic [XLEN-1:0] instr, input int lsb);
    return instr[lsb +: REG_AW];
  endfunction
endpackage

// File: rtl/rv32i_fetch_fifo.sv
// rtl/rv32i_fetch_fifo.sv - synchronous FIFO buffering {pc, instr} fetch responses
// Flush wins over push and pop; push when full and pop when empty are ignored.
module rv32i_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH_W);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !i_flush && !o_full;
  assign w_pop   = i_pop && !i_flush && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/rv32i_fetch_stage.sv
// rtl/rv32i_fetch_stage.sv - RV32I IF stage: imem request channel, response FIFO, IF/ID register
// Optional performance counters are built when RV32I_FETCH_PERF_EN is defined.
module rv32i_fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef RV32I_FETCH_PERF_EN
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_dropped,
`endif
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [XLEN-1:0]   imem_resp_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              if_id_valid,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [XLEN-1:0]   if_id_instr,
  output logic [REG_AW-1:0] if_rs1,
  output logic [REG_AW-1:0] if_rs2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_pending;
  logic [CW-1:0]   r_drop;
  logic            r_if_id_valid;
  logic [XLEN-1:0] r_if_id_pc;
  logic [XLEN-1:0] r_if_id_instr;

  logic [CW-1:0]   w_fifo_count;
  logic [CW-1:0]   w_pending_next;
  logic [CW:0]     w_inflight;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic            w_req_fire;
  logic            w_resp_live;
  logic            w_take;
  logic            w_bypass;
  logic            w_fifo_push;
  logic            w_fifo_pop;
  logic [XLEN-1:0] w_redirect_pc;
  fetch_entry_t    w_fifo_head;
  fetch_entry_t    w_resp_entry;

  assign w_inflight     = {1'b0, r_pending} + {1'b0, w_fifo_count};
  assign imem_req_valid = !rst && !redirect_valid && !w_fifo_full && (w_inflight < DEPTH_W);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_pending_next = r_pending + CW'(w_req_fire) - CW'(imem_resp_valid);
  assign w_redirect_pc  = redirect_pc & ~32'h3;

  // A response landing while the FIFO is empty goes straight to IF/ID for 1-cycle latency.
  assign w_resp_live  = imem_resp_valid && (r_drop == '0) && !redirect_valid;
  assign w_take       = !redirect_valid && !stall;
  assign w_bypass     = w_take && w_fifo_empty && w_resp_live;
  assign w_fifo_push  = w_resp_live && !w_bypass;
  assign w_fifo_pop   = w_take && !w_fifo_empty;
  assign w_resp_entry = '{pc: r_resp_pc, instr: imem_resp_data};

  rv32i_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_fifo_push),
    .i_push_data (w_resp_entry),
    .i_pop       (w_fifo_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_pending     <= '0;
      r_drop        <= '0;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= RV32I_NOP;
    end else begin
      r_pending <= w_pending_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        r_pc          <= w_redirect_pc;
        r_resp_pc     <= w_redirect_pc;
        r_drop        <= w_pending_next;
        r_if_id_valid <= 1'b0;
        r_if_id_instr <= RV32I_NOP;
      end else begin
        if (w_req_fire) r_pc <= r_pc + 32'd4;
        if (w_resp_live) r_resp_pc <= r_resp_pc + 32'd4;
        else if (imem_resp_valid) r_drop <= r_drop - CW'(1);
        if (!stall) begin
          if (!w_fifo_empty) begin
            r_if_id_valid <= 1'b1;
            r_if_id_pc    <= w_fifo_head.pc;
            r_if_id_instr <= w_fifo_head.instr;
          end else if (w_resp_live) begin
            r_if_id_valid <= 1'b1;
            r_if_id_pc    <= r_resp_pc;
            r_if_id_instr <= imem_resp_data;
          end else begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= RV32I_NOP;
          end
        end
      end
    end
  end

  assign if_id_valid = r_if_id_valid;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_rs1      = r_if_id_valid ? reg_field(r_if_id_instr, RS1_LSB) : '0;
  assign if_rs2      = r_if_id_valid ? reg_field(r_if_id_instr, RS2_LSB) : '0;

`ifdef RV32I_FETCH_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_drop  <= '0;
    end else begin
      if (stall && r_if_id_valid && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (imem_resp_valid && ((r_drop != '0) || redirect_valid) && (r_perf_drop != 32'hFFFF_FFFF))
        r_perf_drop <= r_perf_drop + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_dropped      = r_perf_drop;
`endif
endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// tb/tb_rv32i_fetch_stage.sv - scoreboard bench for rv32i_fetch_stage with a bench-side memory model
// Perf counter checks are compiled when RV32I_FETCH_PERF_EN is defined.
module tb_rv32i_fetch_stage;
  import rv32i_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_instr;
  logic [4:0]  if_rs1, if_rs2;
`ifdef RV32I_FETCH_PERF_EN
  logic [31:0] perf_stall_cycles, perf_dropped;
`endif

  rv32i_fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
`ifdef RV32I_FETCH_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_dropped      (perf_dropped),
`endif
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_resp_valid   (imem_resp_valid),
    .imem_resp_data    (imem_resp_data),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .if_id_valid       (if_id_valid),
    .if_id_pc          (if_id_pc),
    .if_id_instr       (if_id_instr),
    .if_rs1            (if_rs1),
    .if_rs2            (if_rs2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] sbq[$];
  logic [31:0] m_pc;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          checks = 0;
  int          errors = 0;
  bit          hash_mode = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (hash_mode) return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    return a + 32'h100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: in-order responses, one per cycle, no earlier than lat cycles after acceptance.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  // Program-order model: accepted fetches form the expected stream; a redirect discards all of it.
  always @(negedge clk) begin
    logic [31:0] exp_pc, exp_i;
    int d;
    if (!rst) begin
      if (if_id_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: IF/ID valid with pc %h but no fetch expected", if_id_pc);
        end else begin
          exp_pc = sbq[0];
          exp_i  = mem_data(exp_pc);
          chk("if_id_pc", if_id_pc, exp_pc);
          chk("if_id_instr", if_id_instr, exp_i);
          chk("if_rs1", 32'(if_rs1), 32'(exp_i[19:15]));
          chk("if_rs2", 32'(if_rs2), 32'(exp_i[24:20]));
          if (!stall && !redirect_valid) void'(sbq.pop_front());
        end
      end else begin
        chk("bubble_instr", if_id_instr, NOP);
        chk("bubble_rs", {22'b0, if_rs1, if_rs2}, 32'd0);
      end
      chk("outstanding_le_depth", 32'((memq.size() + int'(imem_resp_valid)) <= DEPTH), 32'd1);
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, m_pc);
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        memq.push_back('{addr: imem_req_addr, due: d});
        sbq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      if (redirect_valid) begin
        chk("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
        sbq.delete();
        m_pc = redirect_pc & ~32'h3;
      end
    end
  end

  task automatic do_reset(input bit hm, input int l);
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    memq.delete();
    sbq.delete();
    m_pc = RST_PC;
    hash_mode = hm;
    lat = l;
    last_due = 0;
    repeat (2) step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_pending2(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((memq.size() + int'(imem_resp_valid)) == 2) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    int first_acc, first_val, vc;
    bit found;
    logic [31:0] a0;

    // Reset state
    do_reset(1'b0, 1);
    rst = 1'b1;
    #1;
    chk("rst_if_id_valid", 32'(if_id_valid), 32'd0);
    chk("rst_if_id_pc", if_id_pc, 32'd0);
    chk("rst_if_id_instr", if_id_instr, NOP);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);

    // Sequential fetch, 1-cycle memory: latency and throughput
    do_reset(1'b0, 1);
    imem_req_ready = 1'b1;
    #1;
    first_acc = -1;
    first_val = -1;
    for (int i = 0; i < 20; i++) begin
      if (first_acc < 0 && imem_req_valid && imem_req_ready) first_acc = cyc;
      if (first_val < 0 && if_id_valid) first_val = cyc;
      step();
    end
    chk("first_req_to_if_id", 32'(first_val - first_acc), 32'd2);
    vc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if_id_valid) vc++;
    end
    chk("throughput", 32'(vc), 32'd8);

    // Stall holds IF/ID at 0x8 for three cycles total
    do_reset(1'b0, 1);
    imem_req_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_id_valid && if_id_pc == 32'h8) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_setup", 32'(found), 32'd1);
    stall = 1'b1;
    step();
    chk("stall_hold1", if_id_pc, 32'h8);
    step();
    chk("stall_hold2", if_id_pc, 32'h8);
    stall = 1'b0;
    step();
    chk("stall_release_pc", if_id_pc, 32'hC);
    chk("stall_release_valid", 32'(if_id_valid), 32'd1);
`ifdef RV32I_FETCH_PERF_EN
    chk("perf_stall_cycles", perf_stall_cycles, 32'd2);
`endif

    // Redirect to 0x200 with two responses in flight on a 3-cycle memory
    do_reset(1'b0, 3);
    imem_req_ready = 1'b1;
    wait_pending2("redirect_setup");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    redirect_valid = 1'b0;
    chk("redirect_bubble", 32'(if_id_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (if_id_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("redirect_found", 32'(found), 32'd1);
    chk("redirect_first_pc", if_id_pc, 32'h200);
`ifdef RV32I_FETCH_PERF_EN
    chk("perf_dropped", perf_dropped, 32'd2);
`endif

    // Redirect and stall together: redirect wins
    do_reset(1'b0, 1);
    imem_req_ready = 1'b1;
    repeat (6) step();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    stall = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("redir_stall_valid", 32'(if_id_valid), 32'd0);
    chk("redir_stall_pc", imem_req_addr, 32'h200);

    // Ready low for 5 cycles: address stable, pipeline drains to bubbles
    repeat (6) step();
    imem_req_ready = 1'b0;
    a0 = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ready_low_addr", imem_req_addr, a0);
    end
    chk("ready_low_bubble", 32'(if_id_valid), 32'd0);
    imem_req_ready = 1'b1;
    repeat (10) step();

    // Reset with two fetches pending
    do_reset(1'b0, 3);
    imem_req_ready = 1'b1;
    wait_pending2("midreset_setup");
    rst = 1'b1;
    #1;
    chk("midreset_valid", 32'(if_id_valid), 32'd0);
    chk("midreset_instr", if_id_instr, NOP);
    chk("midreset_req_valid", 32'(imem_req_valid), 32'd0);
    memq.delete();
    sbq.delete();
    m_pc = RST_PC;
    last_due = 0;
    imem_resp_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("post_reset_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_reset_addr", imem_req_addr, RST_PC);
    repeat (10) step();

    // Randomized traffic against the program-order model
    do_reset(1'b1, 1);
    for (int i = 0; i < 2000; i++) begin
      step();
      lat = int'($urandom_range(1, 3));
      stall = ($urandom % 4) == 0;
      imem_req_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFF);
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_fetch_stage.md
Name: rv32i_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Drives PC and the instruction-memory valid/ready request channel; buffers in-order responses in a small FIFO.
- Presents the registered instruction to ID, plus rs1/rs2 fields to the hazard unit.
- Consumes the hazard unit's load-use stall (hold) and EX's branch/jump redirect (flush).

Parameters:
- RESET_PC, 32'h0000_0000, PC after reset.
- FIFO_DEPTH, 2, max fetched-but-unconsumed words; power of 2, ≥2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts request.
- imem_req_addr  out  32  word-aligned fetch address (current PC).
- imem_resp_valid  in  1  response data valid; responses in request order, ≥1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- stall  in  1  load-use stall from hazard unit; hold IF/ID and the FIFO head.
- redirect_valid  in  1  taken branch/jump from EX.
- redirect_pc  in  32  target; bits[1:0] ignored (treated 0).
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_pc  out  32  PC of that instruction.
- if_id_instr  out  32  instruction word; 32'h0000_0013 (NOP) when not valid.
- if_rs1  out  5  if_id_instr[19:15] when valid, else 0.
- if_rs2  out  5  if_id_instr[24:20] when valid, else 0.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC; pending=0; drop=0; FIFO empty.
  - if_id_valid=0, if_id_pc=0, if_id_instr=NOP.
  - imem_req_valid=0 while rst is high.
- Request channel:
  - imem_req_valid = !redirect_valid && (pending + fifo_count < FIFO_DEPTH).
  - imem_req_addr = pc.
  - Handshake fires on valid&&ready: pc += 4 (32-bit wrap), pending += 1.
  - Addr/valid may change without ready only on redirect.
- Response:
  - Each imem_resp_valid decrements pending.
  - If drop>0: discard the word and decrement drop. Otherwise push {pc_tag, data} into the FIFO.
  - pc_tag is the oldest-issued address, tracked by a resp_pc register that advances by 4 per live response.
  - FIFO never overflows, guaranteed by the issue rule.
- IF/ID update, in priority order:
  1. redirect_valid: next if_id_valid=0; FIFO flushed; pc=redirect_pc; resp_pc=redirect_pc; drop = pending - resp_this_cycle (post-cycle in-flight count). Overrides stall.
  2. stall: IF/ID and FIFO head hold; FIFO may still fill; requests continue under the issue rule.
  3. Otherwise: if FIFO non-empty, pop head into IF/ID with valid=1; else valid=0 (bubble).
- Latency: response accepted in cycle N appears in IF/ID at N+1 if the FIFO was empty and there is no stall.
- Steady-state throughput is 1 instr/cycle with a 1-cycle-latency memory.
- Boundaries:
  - Response in the redirect cycle is counted into the discard.
  - Redirect while drop>0: new drop = all still-pending responses.
  - FIFO full with stall: no requests issue.
  - Reset mid-transaction: all counters cleared; the memory side must be reset with the core.

Optional Feature:
- RV32I_FETCH_PERF_EN defined:
  - Adds outputs perf_stall_cycles[31:0] (cycles with stall=1 and if_id_valid=1) and perf_dropped[31:0] (discarded responses).
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package rv32i_pkg:
  - XLEN=32, RV32I_NOP=32'h0000_0013.
  - RS1_LSB=15, RS2_LSB=20, REG_AW=5.
  - Default RESET_PC.
- Sub-module rv32i_fetch_fifo:
  - Synchronous FIFO, width 64 ({pc,instr}), depth FIFO_DEPTH.
  - push/pop/flush; flush has priority over push.
  - Outputs count, empty, full.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning addr+32'h100 as data -> if_id_pc 0,4,8,... on consecutive cycles; if_id_instr 0x100,0x104,...; if_rs1/if_rs2 match fields.
- Hazard stall high 2 cycles while if_id_pc=0x8 -> IF/ID holds 0x8 for 3 cycles total, then 0xC; no more than FIFO_DEPTH requests outstanding.
- Redirect to 0x200 with 2 responses in flight (3-cycle memory) -> both stale responses discarded; next valid if_id_pc=0x200; perf_dropped=2 if enabled.
- Redirect and stall in the same cycle -> if_id_valid=0 next cycle; pc=0x200; stall ignored.
- imem_req_ready low 5 cycles -> imem_req_addr stable, bubbles (if_id_instr=NOP, if_rs1=if_rs2=0); fetch resumes in order.
- Assert rst mid-stream with pending=2 -> outputs immediately reset; the first post-reset request addr equals RESET_PC.
